ramz_pingpong: RTL and testbench
================================

// Module: ramz_pingpong
// PURPOSE
//  Multi-bank (ping-pong/ring) successor of the zig-zag/quantiser block RAM. Writer fills one
//  2**RAMADDR_W-word bank while reader drains another; banks hand over via commit/release.
//  Sits between DCT/zig-zag stage and quantiser/RLE so producer and consumer overlap per 8x8 block.
// PARAMETERS
//  RAMADDR_W  6   word address width per bank (bank depth = 2**RAMADDR_W)
//  RAMDATA_W  12  data word width
//  NBANKS     2   number of banks, 2..16, any integer; BANK_W = $clog2(NBANKS) (localparam)
// PORTS
//  clk         in   1           clock, all state on posedge
//  rst_n       in   1           asynchronous active-low reset
//  d           in   RAMDATA_W   write data
//  waddr       in   RAMADDR_W   write word address within current write bank
//  we          in   1           write strobe
//  wr_commit   in   1           current write bank complete; hand to reader
//  wr_ready    out  1           a free bank is available for writing
//  raddr       in   RAMADDR_W   read word address within current read bank
//  rd          in   1           read strobe
//  rd_release  in   1           current read bank consumed; return to writer
//  rd_avail    out  1           a committed bank is available for reading
//  q           out  RAMDATA_W   read data
//  q_valid     out  1           q holds data of an accepted read
//  wr_bank     out  BANK_W      current write bank index
//  rd_bank     out  BANK_W      current read bank index
//  blk_count   out  BANK_W+1    committed, unreleased banks (0..NBANKS)
//  err_clr     in   1           clears sticky error flags
//  wr_err      out  1           sticky: we or wr_commit while !wr_ready
//  rd_err      out  1           sticky: rd or rd_release while !rd_avail
// BEHAVIOUR
//  - Storage NBANKS*2**RAMADDR_W words; physical address = bank*2**RAMADDR_W + word addr. Not reset.
//  - Reset: wr_bank=rd_bank=0, blk_count=0, q_valid=0, wr_err=rd_err=0; wr_ready=1, rd_avail=0.
//  - wr_ready = (blk_count != NBANKS); rd_avail = (blk_count != 0); both combinational.
//  - Write: we && wr_ready -> mem[wr_bank,waddr] <= d. we && !wr_ready -> dropped, wr_err<=1.
//  - Commit: wr_commit && wr_ready -> wr_bank advances (NBANKS-1 wraps to 0), blk_count+1.
//    we in same cycle as wr_commit writes the old (committing) bank.
//  - Read: rd && rd_avail -> read address {rd_bank,raddr} registered; q = mem[registered addr]
//    next cycle, q_valid=1 that cycle only. rd && !rd_avail -> ignored, rd_err<=1, q_valid=0.
//  - Release: rd_release && rd_avail -> rd_bank advances (wraps), blk_count-1. rd in same cycle
//    reads the old (releasing) bank.
//  - Commit and release same cycle (both legal): both pointers advance, blk_count unchanged.
//    At blk_count==0 commit legal, release errors; at ==NBANKS release legal, commit errors.
//  - Reader and writer never address the same bank while both legal: no read-during-write hazard.
//  - Illegal commit/release: no pointer/count change, sticky flag set. err_clr clears flags;
//    a new error in the same cycle as err_clr wins (flag stays 1).
//  - Reset mid-operation: all pointers/flags to reset values at once; prior bank contents
//    treated as discarded (not cleared).
// CONFIGURATION
//  RAMZ_PP_OUTREG_EN defined: extra output register; q and q_valid appear 2 cycles after rd;
//    q resets to 0 and holds last read value between reads; read pipeline flushed on reset.
//  Not defined: 1-cycle latency as above; q undefined until first accepted read and follows
//    registered address (no output register).
// TESTING
//  1 Reset, NBANKS=2: write 0..63 value=addr+100, commit -> blk_count=1, rd_avail=1, wr_bank=1;
//    read addr 5 -> q=105, q_valid 1 cycle after rd (2 with RAMZ_PP_OUTREG_EN).
//  2 Commit twice with no release -> blk_count=2, wr_ready=0; we to addr 0 value 0xFFF dropped
//    (bank 0 addr 0 still reads 100), wr_err=1; err_clr -> wr_err=0.
//  3 blk_count=1, assert wr_commit and rd_release same cycle -> blk_count stays 1, wr_bank and
//    rd_bank each advance by 1.
//  4 NBANKS=3: commit/release 7 times -> wr_bank=rd_bank=1 (wrap), data in each bank intact.
//  5 rd and rd_release with blk_count=0 -> rd_err=1, q_valid=0, rd_bank=0, blk_count=0.
//  6 Assert rst_n=0 mid-fill with blk_count=1 -> same cycle blk_count=0, rd_avail=0, pointers 0,
//    q_valid=0.

Source files
------------

// File: rtl/ramz_pingpong.sv
// Multi-bank ping-pong block RAM between zig-zag and quantiser stages.
// Define RAMZ_PP_OUTREG_EN for a registered read output (2-cycle latency).
module ramz_pingpong #(
  parameter  int RAMADDR_W = 6,
  parameter  int RAMDATA_W = 12,
  parameter  int NBANKS    = 2,
  localparam int BANK_W    = $clog2(NBANKS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RAMDATA_W-1:0] d,
  input  logic [RAMADDR_W-1:0] waddr,
  input  logic                 we,
  input  logic                 wr_commit,
  output logic                 wr_ready,
  input  logic [RAMADDR_W-1:0] raddr,
  input  logic                 rd,
  input  logic                 rd_release,
  output logic                 rd_avail,
  output logic [RAMDATA_W-1:0] q,
  output logic                 q_valid,
  output logic [BANK_W-1:0]    wr_bank,
  output logic [BANK_W-1:0]    rd_bank,
  output logic [BANK_W:0]      blk_count,
  input  logic                 err_clr,
  output logic                 wr_err,
  output logic                 rd_err
);

  localparam int DEPTH = 2 ** RAMADDR_W;
  localparam int MEM_N = NBANKS * DEPTH;
  localparam int AW    = BANK_W + RAMADDR_W;

  logic [RAMDATA_W-1:0] mem [MEM_N];
  logic [AW-1:0]        ra_q;
  logic                 rv_q;
  logic [RAMDATA_W-1:0] mem_q;
  logic                 wr_ok, cm_ok, rd_ok, rl_ok;
  logic                 wr_bad, rd_bad;

  function automatic logic [BANK_W-1:0] nxt(input logic [BANK_W-1:0] b);
    return (b == BANK_W'(NBANKS - 1)) ? '0 : b + 1'b1;
  endfunction

  assign wr_ready = (blk_count != (BANK_W+1)'(NBANKS));
  assign rd_avail = (blk_count != '0);

  assign wr_ok  = we & wr_ready;
  assign cm_ok  = wr_commit & wr_ready;
  assign rd_ok  = rd & rd_avail;
  assign rl_ok  = rd_release & rd_avail;
  assign wr_bad = (we | wr_commit) & ~wr_ready;
  assign rd_bad = (rd | rd_release) & ~rd_avail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank   <= '0;
      rd_bank   <= '0;
      blk_count <= '0;
      wr_err    <= 1'b0;
      rd_err    <= 1'b0;
      ra_q      <= '0;
      rv_q      <= 1'b0;
    end else begin
      if (cm_ok) wr_bank <= nxt(wr_bank);
      if (rl_ok) rd_bank <= nxt(rd_bank);
      case ({cm_ok, rl_ok})
        2'b10:   blk_count <= blk_count + 1'b1;
        2'b01:   blk_count <= blk_count - 1'b1;
        default: blk_count <= blk_count;
      endcase
      // A fresh error outranks a clear in the same cycle
      wr_err <= wr_bad | (wr_err & ~err_clr);
      rd_err <= rd_bad | (rd_err & ~err_clr);
      if (rd_ok) ra_q <= {rd_bank, raddr};
      rv_q <= rd_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[{wr_bank, waddr}] <= d;
  end

  assign mem_q = mem[ra_q];

`ifdef RAMZ_PP_OUTREG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= rv_q;
      if (rv_q) q <= mem_q;
    end
  end
`else
  assign q       = mem_q;
  assign q_valid = rv_q;
`endif

endmodule

// File: tb/tb_ramz_pingpong.sv
// Scoreboard bench for ramz_pingpong: NBANKS=2 and NBANKS=3 instances.
module tb_ramz_pingpong;

`ifdef RAMZ_PP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int data;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] a_d, a_q;
  logic [5:0]  a_waddr, a_raddr;
  logic        a_we, a_cm, a_rd, a_rl, a_clr;
  logic        a_wrdy, a_ravl, a_qv, a_werr, a_rerr;
  logic [0:0]  a_wb, a_rb;
  logic [1:0]  a_blk;

  logic [11:0] b_d, b_q;
  logic [5:0]  b_waddr, b_raddr;
  logic        b_we, b_cm, b_rd, b_rl, b_clr;
  logic        b_wrdy, b_ravl, b_qv, b_werr, b_rerr;
  logic [1:0]  b_wb, b_rb;
  logic [2:0]  b_blk;

  ramz_pingpong #(.RAMADDR_W(6), .RAMDATA_W(12), .NBANKS(2)) u_a (
    .clk(clk), .rst_n(rst_n), .d(a_d), .waddr(a_waddr), .we(a_we),
    .wr_commit(a_cm), .wr_ready(a_wrdy), .raddr(a_raddr), .rd(a_rd),
    .rd_release(a_rl), .rd_avail(a_ravl), .q(a_q), .q_valid(a_qv),
    .wr_bank(a_wb), .rd_bank(a_rb), .blk_count(a_blk),
    .err_clr(a_clr), .wr_err(a_werr), .rd_err(a_rerr)
  );

  ramz_pingpong #(.RAMADDR_W(6), .RAMDATA_W(12), .NBANKS(3)) u_b (
    .clk(clk), .rst_n(rst_n), .d(b_d), .waddr(b_waddr), .we(b_we),
    .wr_commit(b_cm), .wr_ready(b_wrdy), .raddr(b_raddr), .rd(b_rd),
    .rd_release(b_rl), .rd_avail(b_ravl), .q(b_q), .q_valid(b_qv),
    .wr_bank(b_wb), .rd_bank(b_rb), .blk_count(b_blk),
    .err_clr(b_clr), .wr_err(b_werr), .rd_err(b_rerr)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && a_qv) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_q_valid", 1, 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_q", int'(a_q), e.data);
        chk("a_lat", cyc - e.cyc, LAT);
      end
    end
    if (rst_n && b_qv) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_q_valid", 1, 0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_q", int'(b_q), e.data);
        chk("b_lat", cyc - e.cyc, LAT);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_op(input bit we, input int wa, input int dv,
                      input bit rd, input int ra, input int ex,
                      input bit cm, input bit rl, input bit clr);
    a_we = we; a_waddr = 6'(wa); a_d = 12'(dv);
    a_rd = rd; a_raddr = 6'(ra);
    a_cm = cm; a_rl = rl; a_clr = clr;
    if (rd && a_ravl) qa.push_back('{data: ex, cyc: cyc});
    tick();
    a_we = 0; a_rd = 0; a_cm = 0; a_rl = 0; a_clr = 0;
  endtask

  task automatic b_op(input bit we, input int wa, input int dv,
                      input bit rd, input int ra, input int ex,
                      input bit cm, input bit rl);
    b_we = we; b_waddr = 6'(wa); b_d = 12'(dv);
    b_rd = rd; b_raddr = 6'(ra);
    b_cm = cm; b_rl = rl;
    if (rd && b_ravl) qb.push_back('{data: ex, cyc: cyc});
    tick();
    b_we = 0; b_rd = 0; b_cm = 0; b_rl = 0;
  endtask

  initial begin
    a_d = 0; a_waddr = 0; a_raddr = 0;
    a_we = 0; a_cm = 0; a_rd = 0; a_rl = 0; a_clr = 0;
    b_d = 0; b_waddr = 0; b_raddr = 0;
    b_we = 0; b_cm = 0; b_rd = 0; b_rl = 0; b_clr = 0;
    repeat (2) tick();
    chk("rst_wb", a_wb, 0);
    chk("rst_rb", a_rb, 0);
    chk("rst_blk", a_blk, 0);
    chk("rst_wrdy", a_wrdy, 1);
    chk("rst_ravl", a_ravl, 0);
    chk("rst_qv", a_qv, 0);
    chk("rst_werr", a_werr, 0);
    chk("rst_rerr", a_rerr, 0);
    chk("rst_b_blk", b_blk, 0);
    rst_n = 1'b1;
    tick();

    // fill bank 0, commit, read back
    for (int i = 0; i < 64; i++) a_op(1, i, i + 100, 0, 0, 0, 0, 0, 0);
    a_op(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t1_blk", a_blk, 1);
    chk("t1_ravl", a_ravl, 1);
    chk("t1_wb", a_wb, 1);
    chk("t1_wrdy", a_wrdy, 1);
    a_op(0, 0, 0, 1, 5, 105, 0, 0, 0);
    a_op(0, 0, 0, 1, 63, 163, 0, 0, 0);

    // fill part of bank 1, commit -> full
    for (int i = 0; i < 4; i++) a_op(1, i, i + 200, 0, 0, 0, 0, 0, 0);
    a_op(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t2_blk", a_blk, 2);
    chk("t2_wrdy", a_wrdy, 0);
    chk("t2_wb", a_wb, 0);
    a_op(1, 0, 'hFFF, 0, 0, 0, 0, 0, 0);
    chk("t2_werr", a_werr, 1);
    a_op(0, 0, 0, 1, 0, 100, 0, 0, 0);
    a_op(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t2_werr_clr", a_werr, 0);
    a_op(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t2_badcm_blk", a_blk, 2);
    chk("t2_badcm_wb", a_wb, 0);
    chk("t2_badcm_werr", a_werr, 1);
    a_op(0, 0, 0, 0, 0, 0, 0, 0, 1);
    a_op(1, 1, 1, 0, 0, 0, 0, 0, 1);
    chk("t2_err_wins", a_werr, 1);
    a_op(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t2_werr_clr2", a_werr, 0);
    a_op(0, 0, 0, 1, 5, 105, 0, 1, 0);
    chk("t2_rel_rb", a_rb, 1);
    chk("t2_rel_blk", a_blk, 1);

    // simultaneous commit and release; write lands in committing bank
    a_op(1, 7, 'h777, 1, 2, 202, 1, 1, 0);
    chk("t3_blk", a_blk, 1);
    chk("t3_wb", a_wb, 1);
    chk("t3_rb", a_rb, 0);
    a_op(0, 0, 0, 1, 7, 'h777, 0, 0, 0);
    a_op(0, 0, 0, 1, 8, 108, 0, 1, 0);
    chk("t3_rb2", a_rb, 1);
    chk("t3_ravl", a_ravl, 0);

    // read and release with nothing committed
    a_op(0, 0, 0, 1, 0, 0, 0, 1, 0);
    chk("t5_rerr", a_rerr, 1);
    chk("t5_rb", a_rb, 1);
    chk("t5_blk", a_blk, 0);
    chk("t5_werr", a_werr, 0);
    a_op(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t5_rerr_clr", a_rerr, 0);

    // three-bank ring, seven commit/release rounds
    for (int k = 0; k < 3; k++) begin
      b_op(1, 3, 'h300 + k, 0, 0, 0, 0, 0);
      b_op(1, 60, 'h400 + k, 0, 0, 0, 1, 0);
    end
    chk("t4_blk_full", b_blk, 3);
    chk("t4_wrdy", b_wrdy, 0);
    chk("t4_wb", b_wb, 0);
    for (int k = 0; k < 7; k++) begin
      b_op(0, 0, 0, 1, 60, 'h400 + k, 0, 0);
      b_op(0, 0, 0, 1, 3, 'h300 + k, 0, 1);
      if (k + 3 < 7) begin
        b_op(1, 3, 'h300 + k + 3, 0, 0, 0, 0, 0);
        b_op(1, 60, 'h400 + k + 3, 0, 0, 0, 1, 0);
      end
    end
    chk("t4_wb_end", b_wb, 1);
    chk("t4_rb_end", b_rb, 1);
    chk("t4_blk_end", b_blk, 0);
    chk("t4_werr", b_werr, 0);
    chk("t4_rerr", b_rerr, 0);

    // reset while a bank is committed and the next is filling
    a_op(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t6_pre_blk", a_blk, 1);
    a_op(1, 0, 5, 1, 1, 201, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    qa.delete();
    #1;
    chk("t6_blk", a_blk, 0);
    chk("t6_ravl", a_ravl, 0);
    chk("t6_wb", a_wb, 0);
    chk("t6_rb", a_rb, 0);
    chk("t6_qv", a_qv, 0);
    chk("t6_wrdy", a_wrdy, 1);
`ifdef RAMZ_PP_OUTREG_EN
    chk("t6_q_zero", int'(a_q), 0);
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
